// File: rtl/rect_fill.sv
// rect_fill: accepts one rectangle command at a time and turns it into a
// raster-ordered burst of single-pixel framebuffer writes, one per cycle.
// Geometry is clipped to the panel, so addresses never leave the framebuffer.
//
// Command handshake: a command is taken on a rising clock edge where
// cmd_valid && cmd_ready. cmd_ready is high only while idle, and every cmd_*
// field is captured on that edge. cmd_valid while busy is ignored, not queued.
// The write side has no backpressure: each cycle with we=1 is one pixel written.
module rect_fill #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [6:0]        cmd_x,
  input  logic [4:0]        cmd_y,
  input  logic [6:0]        cmd_w,
  input  logic [4:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_value,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Panel limits at the widths of the clipped bound sums.
  localparam logic [7:0] WIDTH_L  = 8'(WIDTH);
  localparam logic [5:0] HEIGHT_L = 6'(HEIGHT);

  logic [1:0]        r_state;
  logic              r_clear;
  logic [6:0]        r_x;
  logic [4:0]        r_y;
  logic [6:0]        r_w;
  logic [4:0]        r_h;
  logic [DATA_W-1:0] r_color;
  logic [6:0]        r_x0;
  logic [7:0]        r_x_end;
  logic [5:0]        r_y_end;
  logic [6:0]        r_col;
  logic [4:0]        r_row;

  logic [7:0]        w_sum_x;
  logic [5:0]        w_sum_y;
  logic [6:0]        w_set_x0;
  logic [4:0]        w_set_y0;
  logic [7:0]        w_set_x_end;
  logic [5:0]        w_set_y_end;
  logic              w_set_empty;
  logic              w_at_row_end;
  logic              w_at_last;
  logic [6:0]        w_next_col;
  logic [4:0]        w_next_row;
  logic [6:0]        w_addr_col;
  logic [4:0]        w_addr_row;
  logic [ADDR_W-1:0] w_addr;

  assign dbg_state = r_state;

  // Clipped bounds from the captured command, plus cursor stepping and address.
  always_comb begin
    w_sum_x = {1'b0, r_x} + {1'b0, r_w};
    w_sum_y = {1'b0, r_y} + {1'b0, r_h};
    if (r_clear) begin
      w_set_x0    = 7'd0;
      w_set_y0    = 5'd0;
      w_set_x_end = WIDTH_L;
      w_set_y_end = HEIGHT_L;
      w_set_empty = 1'b0;
    end else begin
      w_set_x0    = r_x;
      w_set_y0    = r_y;
      w_set_x_end = (w_sum_x > WIDTH_L) ? WIDTH_L : w_sum_x;
      w_set_y_end = (w_sum_y > HEIGHT_L) ? HEIGHT_L : w_sum_y;
      // An origin off-panel or a zero dimension leaves nothing to draw.
      w_set_empty = ({1'b0, r_x} >= WIDTH_L) || ({1'b0, r_y} >= HEIGHT_L) ||
                    (r_w == 7'd0) || (r_h == 5'd0);
    end

    w_at_row_end = ({1'b0, r_col} == (r_x_end - 8'd1));
    w_at_last    = w_at_row_end && ({1'b0, r_row} == (r_y_end - 6'd1));
    w_next_col   = w_at_row_end ? r_x0 : (r_col + 7'd1);
    w_next_row   = w_at_row_end ? (r_row + 5'd1) : r_row;

    // In SETUP the address is for the first pixel; in WRITE it is for the next.
    if (r_state == S_SETUP) begin
      w_addr_col = w_set_x0;
      w_addr_row = w_set_y0;
    end else begin
      w_addr_col = w_next_col;
      w_addr_row = w_next_row;
    end
    w_addr = ADDR_W'(w_addr_row) * ADDR_W'(WIDTH) + ADDR_W'(w_addr_col);
  end

  // Command FSM with registered outputs; the cursor tracks the pixel on the bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_clear       <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_w           <= '0;
      r_h           <= '0;
      r_color       <= '0;
      r_x0          <= '0;
      r_x_end       <= '0;
      r_y_end       <= '0;
      r_col         <= '0;
      r_row         <= '0;
      cmd_ready     <= 1'b1;
      we            <= 1'b0;
      write_address <= '0;
      write_value   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_clear   <= cmd_clear;
            r_x       <= cmd_x;
            r_y       <= cmd_y;
            r_w       <= cmd_w;
            r_h       <= cmd_h;
            r_color   <= cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_set_empty) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x0          <= w_set_x0;
            r_x_end       <= w_set_x_end;
            r_y_end       <= w_set_y_end;
            r_col         <= w_set_x0;
            r_row         <= w_set_y0;
            we            <= 1'b1;
            write_address <= w_addr;
            write_value   <= r_color;
            r_state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_at_last) begin
            // Address and value hold the last pixel while we is low.
            we      <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_col         <= w_next_col;
            r_row         <= w_next_row;
            write_address <= w_addr;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          we        <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rect_fill.md
# rect_fill

Command-driven rectangle fill engine on the write side of the panel framebuffer RAM. It accepts one rectangle command at a time and converts it into a raster-ordered burst of single-pixel writes. Its `write_address`/`write_value`/`we` outputs connect directly to the write port that the panel scan stage reads from. Upstream command sources (animation logic, host loader) use it to draw or clear regions without computing framebuffer addresses themselves.

## Interface
- `WIDTH`, 32: panel columns; framebuffer row pitch in words.
- `HEIGHT`, 16: panel rows.
- `ADDR_W`, 16: write address width.
- `DATA_W`, 16: pixel word width.
- `clock`  in  1  single system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  engine idle and able to accept a command.
- `cmd_clear`  in  1  1 = fill the whole screen; geometry fields ignored.
- `cmd_x`  in  7  left column.
- `cmd_y`  in  5  top row.
- `cmd_w`  in  7  width in pixels (0 allowed).
- `cmd_h`  in  5  height in pixels (0 allowed).
- `cmd_color`  in  DATA_W  pixel value to write.
- `write_address`  out  ADDR_W  framebuffer address, row*WIDTH + column.
- `write_value`  out  DATA_W  pixel value.
- `we`  out  1  write strobe; one pixel per cycle while high.
- `busy`  out  1  command in progress (not IDLE).
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
- All outputs are registered. Reset values: `cmd_ready`=1, `we`=0, `write_address`=0, `write_value`=0, `busy`=0, `done`=0, state=IDLE.
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. All cmd fields are captured on that edge. `cmd_ready` is 1 only in IDLE. `cmd_valid` outside IDLE is ignored and not queued.
- States:
  - IDLE: wait for handshake -> SETUP.
  - SETUP: compute clipped bounds. If the clipped pixel count N is 0 -> DONE; otherwise -> WRITE with the cursor at (x0, y0).
  - WRITE: emit one write per cycle in row-major order (column increments first; at x_end-1 the column wraps to x0 and the row increments). After the write at (x_end-1, y_end-1) -> DONE.
  - DONE: pulse `done` for one cycle -> IDLE.
- Clipping (fill mode):
  - x0 = cmd_x; y0 = cmd_y.
  - x_end = min(cmd_x + cmd_w, WIDTH), with the sum computed at 8 bits so it cannot overflow.
  - y_end = min(cmd_y + cmd_h, HEIGHT), with the sum computed at 6 bits.
  - N = 0 if cmd_x >= WIDTH, cmd_y >= HEIGHT, cmd_w == 0 or cmd_h == 0.
- Clear mode: x0=0, y0=0, x_end=WIDTH, y_end=HEIGHT, so N = WIDTH*HEIGHT.
- Address: row*WIDTH + column, truncated to ADDR_W. Maximum is WIDTH*HEIGHT-1. Addresses never fall outside the framebuffer.
- `write_value` = captured cmd_color for every write of the command.
- No write backpressure: the RAM accepts one write per cycle unconditionally.
- `reset_n` low mid-command: outputs go to reset values asynchronously and the remainder of the command is discarded. Pixels already written stay written.

## Timing
- Let A = the cycle in which the handshake is sampled.
- A+1: SETUP. `busy`=1, `cmd_ready`=0, `we`=0.
- A+2 .. A+1+N: `we`=1 with valid `write_address`/`write_value`. Writes are back-to-back with no gaps, including across row wraps.
- A+2+N: `done`=1, `we`=0, `busy`=1.
- A+3+N: IDLE. `cmd_ready`=1, `busy`=0. This is the earliest cycle a new command can be accepted.
- N=0: `done` in A+2, `cmd_ready` in A+3, and no `we` cycles.
- `write_address`/`write_value` hold their last values when `we`=0.

## Test plan
- Reset: assert `reset_n`=0 with random inputs -> `cmd_ready`=1, `we`=0, `busy`=0, `done`=0, `write_address`=0.
- Basic fill: x=3, y=1, w=2, h=2, color=0x0007 at default params -> `we` for 4 cycles starting at A+2, addresses 35, 36, 67, 68, value 0x0007; `done` at A+6; `cmd_ready` at A+7.
- Clipping: x=30, y=15, w=4, h=3 -> exactly 2 writes (addresses 510, 511); `done` at A+4. Separately, x=40, w=5 -> 0 writes, `done` at A+2.
- Zero size: w=0, h=5 -> no `we`; `done` pulse at A+2; `cmd_ready` at A+3.
- Clear: `cmd_clear`=1, color=0x0005 -> 512 consecutive writes with addresses 0..511 in order, all 0x0005; `done` at A+514.
- Busy and reset: hold `cmd_valid`=1 with new fields during a fill -> command not accepted and writes unchanged. Pull `reset_n` low mid-burst -> `we` drops immediately, no `done`, and the engine accepts a fresh command after release.
